alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Upstream/downstream control stage wrapped around the 2-bit-opcode ALU (add/sub/mul-low/zero).
- Holds a small register file and accepts register-addressed commands over a valid/ready interface.
- For each command, reads two operands, drives the ALU for one cycle and captures its 32-bit result.
- Returns the result over a valid/ready response port and writes it back to the destination register when the response is accepted.

Parameters:
- NREGS, 8, number of 32-bit registers; power of two, ≥2.
- AW, 3, register address width = log2(NREGS).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- io_cmd_valid  in  1  command present.
- io_cmd_ready  out  1  sequencer can accept a command.
- io_cmd_op  in  2  ALU opcode: 0 add, 1 sub, 2 mul (low 32 bits), 3 result 0.
- io_cmd_rs1  in  AW  source register for the ALU A operand.
- io_cmd_rs2  in  AW  source register for the ALU B operand.
- io_cmd_rd  in  AW  destination register.
- io_wr_en  in  1  external register write (operand preload).
- io_wr_addr  in  AW  external write address.
- io_wr_data  in  32  external write data.
- io_alu_A  out  32  to the ALU A input.
- io_alu_B  out  32  to the ALU B input.
- io_alu_op  out  2  to the ALU opcode input.
- io_alu_out  in  32  from the ALU result; combinational in A/B/op.
- io_rsp_valid  out  1  result available.
- io_rsp_ready  in  1  consumer accepts the result.
- io_rsp_data  out  32  result value.
- io_rsp_rd  out  AW  destination register of the result.
- io_op_count  out  CNTW  count of completed responses.

Behaviour:
- States:
  - IDLE: io_cmd_ready=1.
  - EXEC: io_alu_* driven from the operand registers.
  - RESP: io_rsp_valid=1.
- Reset, while asserted and in the cycle it takes effect:
  - state=IDLE; all registers, operand registers (A, B, op, rd) and result register = 0; io_op_count=0.
  - io_cmd_ready forced 0; io_rsp_valid=0.
  - Any command or write presented during reset is discarded.
- IDLE, cmd fire (valid&ready) at edge T:
  - Latch A=reg[rs1], B=reg[rs2], op, rd.
  - Operands are read from the register contents before edge T; a same-edge external write is not bypassed.
  - Next state EXEC.
- EXEC (cycle T+1):
  - io_alu_A/B/op come from the latched registers; io_cmd_ready=0.
  - At the closing edge, capture io_alu_out into the result register; next state RESP.
- RESP (cycle T+2 onward):
  - io_rsp_valid=1; io_rsp_data and io_rsp_rd are stable until fire.
  - On fire: reg[rd] <= result; io_op_count += 1 (wraps at 2^CNTW); next state IDLE.
  - While io_rsp_ready=0: hold indefinitely, with no change to data or the counter.
- Latency and throughput:
  - cmd fire to first rsp_valid = 2 cycles.
  - Next cmd accepted at the earliest in the cycle after rsp fire, so minimum issue interval is 3 cycles.
  - A back-to-back dependent command therefore sees the written-back value.
- io_alu_A/B/op keep their last latched values outside EXEC; they are 0 after reset.
- External write:
  - Accepted in any state except during reset; takes effect at the edge.
  - Writes during EXEC/RESP to a source register do not affect the in-flight operands.
  - If the external write and the writeback target the same address at the same edge, writeback wins.
  - Different addresses at the same edge: both are written.
- rs1==rs2 is legal; rd may equal rs1/rs2, since operands are already latched.
- Arithmetic is done in the ALU: add and sub wrap modulo 2^32; mul returns the low 32 bits of the 64-bit product. The sequencer does no arithmetic except the counter.
- Reset asserted in EXEC or RESP: the in-flight operation is aborted, no writeback occurs, and the counter is cleared.

Test Plan:
- Preload r1=5, r2=3; cmd op=0 rs1=1 rs2=2 rd=3 with rsp_ready=1 -> io_alu_A=5, io_alu_B=3 in T+1; rsp_valid at T+2 with data 8, rd 3; r3=8 afterwards; io_op_count=1.
- Sub wrap: r1=3, r2=5, op=1 -> rsp_data 0xFFFFFFFE. Mul: r1=r2=0x00010000, op=2 -> rsp_data 0x00000000. op=3 -> 0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, data and rd stable, cmd_ready=0, count unchanged; on release, exactly one writeback and count +1.
- Dependent back-to-back: cmd r3=r1+r2 (5+3), then r4=r3+r3 presented continuously -> second cmd accepted the cycle after the first rsp fire; result 16.
- Collision: external write r3=0xAAAA on the same edge as the rsp fire writeback of 8 to r3 -> r3=8. Same-edge external write r1=100 with cmd fire reading r1=5 -> operand A=5.
- Reset mid-op: assert reset in EXEC -> next cycle rsp_valid=0, cmd_ready=0 during reset, all registers 0, count 0; after release cmd_ready=1 and a fresh add of 0+0 returns 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Control stage around a 2-bit-opcode ALU: register-addressed commands in,
// one ALU cycle per command, result returned over valid/ready and written back on accept.
module alu_op_sequencer #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned CNTW  = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_cmd_valid,
    output logic            io_cmd_ready,
    input  logic [1:0]      io_cmd_op,
    input  logic [AW-1:0]   io_cmd_rs1,
    input  logic [AW-1:0]   io_cmd_rs2,
    input  logic [AW-1:0]   io_cmd_rd,
    input  logic            io_wr_en,
    input  logic [AW-1:0]   io_wr_addr,
    input  logic [31:0]     io_wr_data,
    output logic [31:0]     io_alu_A,
    output logic [31:0]     io_alu_B,
    output logic [1:0]      io_alu_op,
    input  logic [31:0]     io_alu_out,
    output logic            io_rsp_valid,
    input  logic            io_rsp_ready,
    output logic [31:0]     io_rsp_data,
    output logic [AW-1:0]   io_rsp_rd,
    output logic [CNTW-1:0] io_op_count
);

    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   regs [NREGS];
    logic [DW-1:0]   opa_q;
    logic [DW-1:0]   opb_q;
    logic [1:0]      op_q;
    logic [AW-1:0]   rd_q;
    logic [DW-1:0]   result_q;
    logic [CNTW-1:0] count_q;
    logic            cmd_fire;
    logic            rsp_fire;

    // Handshakes are suppressed while reset is held so nothing is accepted.
    always_comb begin
        state_d      = state_q;
        io_cmd_ready = 1'b0;
        io_rsp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                io_cmd_ready = ~reset;
                if (io_cmd_valid && !reset) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                io_rsp_valid = ~reset;
                if (io_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cmd_fire = io_cmd_valid & io_cmd_ready;
    assign rsp_fire = io_rsp_valid & io_rsp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Writeback is assigned after the external write so it wins on an address clash.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
            count_q  <= '0;
        end else begin
            if (cmd_fire) begin
                opa_q <= regs[io_cmd_rs1];
                opb_q <= regs[io_cmd_rs2];
                op_q  <= io_cmd_op;
                rd_q  <= io_cmd_rd;
            end
            if (state_q == EXEC) begin
                result_q <= io_alu_out;
            end
            if (io_wr_en) begin
                regs[io_wr_addr] <= io_wr_data;
            end
            if (rsp_fire) begin
                regs[rd_q] <= result_q;
                count_q    <= count_q + CNTW'(1);
            end
        end
    end

    assign io_alu_A    = opa_q;
    assign io_alu_B    = opb_q;
    assign io_alu_op   = op_q;
    assign io_rsp_data = result_q;
    assign io_rsp_rd   = rd_q;
    assign io_op_count = count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: transaction-level model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_alu_op_sequencer;

    localparam int unsigned NREGS = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned CNTW  = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            io_cmd_valid = 1'b0;
    logic            io_cmd_ready;
    logic [1:0]      io_cmd_op = '0;
    logic [AW-1:0]   io_cmd_rs1 = '0;
    logic [AW-1:0]   io_cmd_rs2 = '0;
    logic [AW-1:0]   io_cmd_rd = '0;
    logic            io_wr_en = 1'b0;
    logic [AW-1:0]   io_wr_addr = '0;
    logic [31:0]     io_wr_data = '0;
    logic [31:0]     io_alu_A;
    logic [31:0]     io_alu_B;
    logic [1:0]      io_alu_op;
    logic [31:0]     io_alu_out;
    logic            io_rsp_valid;
    logic            io_rsp_ready = 1'b1;
    logic [31:0]     io_rsp_data;
    logic [AW-1:0]   io_rsp_rd;
    logic [CNTW-1:0] io_op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int ops_done = 0;
    bit chk_en   = 1'b0;

    alu_op_sequencer #(.NREGS(NREGS), .AW(AW), .CNTW(CNTW)) dut (
        .clock(clock), .reset(reset),
        .io_cmd_valid(io_cmd_valid), .io_cmd_ready(io_cmd_ready),
        .io_cmd_op(io_cmd_op), .io_cmd_rs1(io_cmd_rs1), .io_cmd_rs2(io_cmd_rs2),
        .io_cmd_rd(io_cmd_rd),
        .io_wr_en(io_wr_en), .io_wr_addr(io_wr_addr), .io_wr_data(io_wr_data),
        .io_alu_A(io_alu_A), .io_alu_B(io_alu_B), .io_alu_op(io_alu_op),
        .io_alu_out(io_alu_out),
        .io_rsp_valid(io_rsp_valid), .io_rsp_ready(io_rsp_ready),
        .io_rsp_data(io_rsp_data), .io_rsp_rd(io_rsp_rd),
        .io_op_count(io_op_count)
    );

    always #5 clock = ~clock;

    // Stand-in ALU attached to the sequencer.
    always_comb begin
        case (io_alu_op)
            2'd0:    io_alu_out = io_alu_A + io_alu_B;
            2'd1:    io_alu_out = io_alu_A - io_alu_B;
            2'd2:    io_alu_out = io_alu_A * io_alu_B;
            default: io_alu_out = 32'd0;
        endcase
    end

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd0:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            2'd1:    return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            2'd2:    return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one op in flight, response offered from its second cycle on.
    logic [31:0]     m_regs [NREGS];
    logic [CNTW-1:0] m_count = '0;
    bit              m_busy = 1'b0;
    int              m_age = 0;
    logic [31:0]     m_a = '0, m_b = '0, m_res = '0;
    logic [1:0]      m_op = '0;
    logic [AW-1:0]   m_rd = '0;

    always @(posedge clock) begin
        bit take, give;
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) m_regs[i] = '0;
            m_count = '0; m_busy = 1'b0; m_age = 0;
            m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_res = '0;
        end else begin
            take = !m_busy && io_cmd_valid;
            give = m_busy && (m_age >= 2) && io_rsp_ready;
            if (take) begin
                m_a   = m_regs[io_cmd_rs1];
                m_b   = m_regs[io_cmd_rs2];
                m_op  = io_cmd_op;
                m_rd  = io_cmd_rd;
                m_res = ref_alu(io_cmd_op, m_a, m_b);
                m_busy = 1'b1;
                m_age  = 1;
            end else if (m_busy && !give && m_age < 2) begin
                m_age = m_age + 1;
            end
            if (io_wr_en) m_regs[io_wr_addr] = io_wr_data;
            if (give) begin
                m_regs[m_rd] = m_res;
                m_count = m_count + 1'b1;
                m_busy  = 1'b0;
                m_age   = 0;
            end
        end
    end

    // Compare every cycle, mid-cycle.
    always @(negedge clock) begin
        bit exp_valid;
        if (chk_en) begin
            exp_valid = !reset && m_busy && (m_age >= 2);
            check("cmd_ready", 32'(io_cmd_ready), 32'(!reset && !m_busy));
            check("rsp_valid", 32'(io_rsp_valid), 32'(exp_valid));
            check("alu_A", io_alu_A, m_a);
            check("alu_B", io_alu_B, m_b);
            check("alu_op", 32'(io_alu_op), 32'(m_op));
            check("op_count", 32'(io_op_count), 32'(m_count));
            if (exp_valid) begin
                check("rsp_data", io_rsp_data, m_res);
                check("rsp_rd", 32'(io_rsp_rd), 32'(m_rd));
            end
            for (int i = 0; i < int'(NREGS); i++)
                check($sformatf("reg%0d", i), dut.regs[i], m_regs[i]);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        io_wr_en = 1'b1; io_wr_addr = a; io_wr_data = d;
        step();
        io_wr_en = 1'b0;
    endtask

    // Present a command until accepted; returns in the EXEC cycle.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                         input logic [AW-1:0] rd, input bit keep);
        bit fired = 1'b0;
        io_cmd_op = op; io_cmd_rs1 = rs1; io_cmd_rs2 = rs2; io_cmd_rd = rd;
        io_cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !fired; i++) begin
            @(negedge clock);
            if (io_cmd_ready) fired = 1'b1;
            step();
        end
        if (!keep) io_cmd_valid = 1'b0;
        if (!fired) check("cmd_accept_timeout", 32'(fired), 32'd1);
    endtask

    // Wait for a response and check it; steps past the edge when it fires.
    task automatic await_rsp(input string name, input logic [31:0] data, input logic [AW-1:0] rd);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            if (io_rsp_valid) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 32'(seen), 32'd1);
        check({name, "_data"}, io_rsp_data, data);
        check({name, "_rd"}, 32'(io_rsp_rd), 32'(rd));
        if (io_rsp_ready) begin
            step();
            ops_done++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        step(); step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("rst_cmd_ready", 32'(io_cmd_ready), 32'd1);
        check("rst_count", 32'(io_op_count), 32'd0);
        step();

        // Basic add with latency checks
        wr(3'd1, 32'd5); wr(3'd2, 32'd3);
        issue(2'd0, 3'd1, 3'd2, 3'd3, 1'b0);
        check("exec_A", io_alu_A, 32'd5);
        check("exec_B", io_alu_B, 32'd3);
        @(negedge clock);
        check("exec_no_valid", 32'(io_rsp_valid), 32'd0);
        await_rsp("add", 32'd8, 3'd3);
        check("add_count", 32'(io_op_count), 32'd1);
        check("add_wb", dut.regs[3], 32'd8);
        check("model_r3", m_regs[3], 32'd8);

        // Opcode coverage and wrap
        wr(3'd1, 32'd3); wr(3'd2, 32'd5);
        issue(2'd1, 3'd1, 3'd2, 3'd5, 1'b0);
        await_rsp("sub_wrap", 32'hFFFF_FFFE, 3'd5);
        wr(3'd1, 32'h0001_0000); wr(3'd2, 32'h0001_0000);
        issue(2'd2, 3'd1, 3'd2, 3'd6, 1'b0);
        await_rsp("mul_ovf", 32'h0000_0000, 3'd6);
        wr(3'd1, 32'h0001_0001); wr(3'd2, 32'd3);
        issue(2'd2, 3'd1, 3'd2, 3'd6, 1'b0);
        await_rsp("mul", 32'h0003_0003, 3'd6);
        wr(3'd1, 32'd7); wr(3'd2, 32'd9);
        issue(2'd3, 3'd1, 3'd2, 3'd7, 1'b0);
        await_rsp("zero", 32'd0, 3'd7);
        wr(3'd1, 32'hFFFF_FFFF); wr(3'd2, 32'd2);
        issue(2'd0, 3'd1, 3'd2, 3'd7, 1'b0);
        await_rsp("add_wrap", 32'd1, 3'd7);
        issue(2'd0, 3'd2, 3'd2, 3'd2, 1'b0);
        await_rsp("rs_eq_rd", 32'd4, 3'd2);

        // Backpressure, plus a write to a source register while in flight
        wr(3'd1, 32'd7); wr(3'd2, 32'd6);
        io_rsp_ready = 1'b0;
        issue(2'd2, 3'd1, 3'd2, 3'd4, 1'b0);
        await_rsp("bp_first", 32'd42, 3'd4);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k == 0) wr(3'd1, 32'd999);
            @(negedge clock);
            check("bp_valid", 32'(io_rsp_valid), 32'd1);
            check("bp_data", io_rsp_data, 32'd42);
            check("bp_rd", 32'(io_rsp_rd), 32'd4);
            check("bp_cmd_ready", 32'(io_cmd_ready), 32'd0);
            check("bp_count", 32'(io_op_count), 32'(ops_done));
        end
        step();
        io_rsp_ready = 1'b1;
        step();
        ops_done++;
        check("bp_count_inc", 32'(io_op_count), 32'(ops_done));
        check("bp_wb", dut.regs[4], 32'd42);
        check("bp_src_kept", dut.regs[1], 32'd999);

        // Dependent back-to-back with cmd_valid held
        wr(3'd1, 32'd5); wr(3'd2, 32'd3);
        issue(2'd0, 3'd1, 3'd2, 3'd3, 1'b1);
        io_cmd_rs1 = 3'd3; io_cmd_rs2 = 3'd3; io_cmd_rd = 3'd4;
        await_rsp("dep_first", 32'd8, 3'd3);
        @(negedge clock);
        check("dep_ready_after_fire", 32'(io_cmd_ready), 32'd1);
        step();
        io_cmd_valid = 1'b0;
        check("dep_A", io_alu_A, 32'd8);
        check("dep_B", io_alu_B, 32'd8);
        await_rsp("dep_second", 32'd16, 3'd4);

        // Writeback beats external write to the same address
        io_rsp_ready = 1'b0;
        issue(2'd0, 3'd1, 3'd2, 3'd3, 1'b0);
        await_rsp("coll_rsp", 32'd8, 3'd3);
        step();
        io_rsp_ready = 1'b1;
        wr(3'd3, 32'h0000_AAAA);
        ops_done++;
        check("coll_same", dut.regs[3], 32'd8);
        io_rsp_ready = 1'b0;
        issue(2'd0, 3'd1, 3'd2, 3'd5, 1'b0);
        await_rsp("coll2_rsp", 32'd8, 3'd5);
        step();
        io_rsp_ready = 1'b1;
        wr(3'd6, 32'h0000_1234);
        ops_done++;
        check("coll_diff_wb", dut.regs[5], 32'd8);
        check("coll_diff_ext", dut.regs[6], 32'h0000_1234);

        // Same-edge external write is not bypassed into operands
        io_wr_en = 1'b1; io_wr_addr = 3'd1; io_wr_data = 32'd100;
        issue(2'd0, 3'd1, 3'd2, 3'd7, 1'b0);
        io_wr_en = 1'b0;
        check("nobypass_A", io_alu_A, 32'd5);
        await_rsp("nobypass", 32'd8, 3'd7);
        check("nobypass_r1", dut.regs[1], 32'd100);
        check("count_total", 32'(io_op_count), 32'(ops_done));

        // Reset during EXEC aborts the operation
        issue(2'd0, 3'd1, 3'd2, 3'd3, 1'b0);
        reset = 1'b1;
        step();
        @(negedge clock);
        check("rst_mid_cmd_ready", 32'(io_cmd_ready), 32'd0);
        check("rst_mid_valid", 32'(io_rsp_valid), 32'd0);
        check("rst_mid_count", 32'(io_op_count), 32'd0);
        check("rst_mid_r3", dut.regs[3], 32'd0);
        check("rst_mid_r1", dut.regs[1], 32'd0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", 32'(io_cmd_ready), 32'd1);
        step();
        issue(2'd0, 3'd1, 3'd2, 3'd1, 1'b0);
        await_rsp("post_rst_add", 32'd0, 3'd1);
        check("post_rst_count", 32'(io_op_count), 32'd1);

        step(); step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
